weight_load_ctrl: RTL and testbench

- Sequencer that streams a layer's parameters from a valid/ready word stream into the weight memory: all weights, then all biases.
- Generates the weight memory's write strobes (weight_write, bias_write), its four write indices, and its write data.
- Sits between the off-chip/testbench parameter source and the weight memory; one instance per layer.
- Signals done once the last bias has been written.

---
 rtl/weight_load_ctrl.sv | 158 +++++++++++++++
 tb/tb_weight_load_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
// Streams one layer's weights, then its biases, from a valid/ready word source
// into the weight memory, generating registered write strobes, indices and data.
module weight_load_ctrl #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DIM         = 1,
  parameter int DATA_SIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 weight_write,
  output logic                 bias_write,
  output logic [15:0]          index_in,
  output logic [15:0]          index_out,
  output logic [15:0]          index_k_y,
  output logic [15:0]          index_k_x,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  localparam longint W_TOTAL = longint'(NUM_INPUTS) * NUM_OUTPUTS * DIM * DIM;

  generate
    if (W_TOTAL >= 65536 || NUM_OUTPUTS >= 65536 || W_TOTAL < 1) begin : g_bad_params
      $error("weight_load_ctrl: parameter products must be in 1..65535");
    end
  endgenerate

  localparam logic [15:0] DIM_M1 = 16'(DIM - 1);
  localparam logic [15:0] NO_M1  = 16'(NUM_OUTPUTS - 1);
  localparam logic [15:0] NI_M1  = 16'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, FLUSH} state_t;

  state_t                 state_q;
  logic [15:0]            kx_q, ky_q, out_q, in_q, bias_q;
  logic [15:0]            kx_d, ky_d, out_d, in_d, bias_d;
  logic                   weight_write_q, bias_write_q, busy_q, done_q;
  logic [15:0]            idx_in_q, idx_out_q, idx_ky_q, idx_kx_q;
  logic [DATA_SIZE-1:0]   data_q;
  logic                   accept, w_last, b_last;

  assign in_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign accept   = in_valid && in_ready;
  assign w_last   = (kx_q == DIM_M1) && (ky_q == DIM_M1) && (out_q == NO_M1) && (in_q == NI_M1);
  assign b_last   = (bias_q == NO_M1);

  // Weight counter chain: kx fastest, then ky, out, in; wraps to all-zero after the last weight.
  always_comb begin
    kx_d   = kx_q + 16'd1;
    ky_d   = ky_q;
    out_d  = out_q;
    in_d   = in_q;
    bias_d = bias_q + 16'd1;
    if (kx_q == DIM_M1) begin
      kx_d = 16'd0;
      ky_d = ky_q + 16'd1;
      if (ky_q == DIM_M1) begin
        ky_d  = 16'd0;
        out_d = out_q + 16'd1;
        if (out_q == NO_M1) begin
          out_d = 16'd0;
          in_d  = (in_q == NI_M1) ? 16'd0 : in_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      kx_q           <= '0;
      ky_q           <= '0;
      out_q          <= '0;
      in_q           <= '0;
      bias_q         <= '0;
      weight_write_q <= 1'b0;
      bias_write_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      idx_in_q       <= '0;
      idx_out_q      <= '0;
      idx_ky_q       <= '0;
      idx_kx_q       <= '0;
      data_q         <= '0;
    end else begin
      weight_write_q <= 1'b0;
      bias_write_q   <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_W;
            busy_q  <= 1'b1;
            kx_q    <= '0;
            ky_q    <= '0;
            out_q   <= '0;
            in_q    <= '0;
            bias_q  <= '0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            weight_write_q <= 1'b1;
            idx_in_q       <= in_q;
            idx_out_q      <= out_q;
            idx_ky_q       <= ky_q;
            idx_kx_q       <= kx_q;
            data_q         <= in_data;
            kx_q           <= kx_d;
            ky_q           <= ky_d;
            out_q          <= out_d;
            in_q           <= in_d;
            if (w_last) begin
              state_q <= LOAD_B;
              bias_q  <= '0;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            bias_write_q <= 1'b1;
            idx_in_q     <= '0;
            idx_out_q    <= '0;
            idx_ky_q     <= '0;
            idx_kx_q     <= bias_q;
            data_q       <= in_data;
            bias_q       <= bias_d;
            if (b_last) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // The final bias strobe is on the bus this cycle; completion follows.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign weight_write = weight_write_q;
  assign bias_write   = bias_write_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign index_in     = idx_in_q;
  assign index_out    = idx_out_q;
  assign index_k_y    = idx_ky_q;
  assign index_k_x    = idx_kx_q;
  assign out_data     = data_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboarded bench: a 2x3x2 instance for full/backpressure/abort loads and a
// 1x1x1 instance for the minimum configuration with a back-to-back restart.
module tb_weight_load_ctrl;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam int D  = 2;
  localparam int NW = NI * NO * D * D;  // 24 weights
  localparam int NT = NW + NO;          // 27 words per load

  typedef struct {
    logic        is_bias;
    logic [15:0] i, o, ky, kx;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, weight_write, bias_write, busy, done;
  logic [15:0] index_in, index_out, index_k_y, index_k_x;
  logic [63:0] out_data;

  logic        m_start = 1'b0, m_in_valid = 1'b0;
  logic [63:0] m_in_data = '0;
  logic        m_in_ready, m_weight_write, m_bias_write, m_busy, m_done;
  logic [15:0] m_index_in, m_index_out, m_index_k_y, m_index_k_x;
  logic [63:0] m_out_data;

  weight_load_ctrl #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DIM(D), .DATA_SIZE(64)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .weight_write(weight_write), .bias_write(bias_write),
    .index_in(index_in), .index_out(index_out), .index_k_y(index_k_y), .index_k_x(index_k_x),
    .out_data(out_data), .busy(busy), .done(done));

  weight_load_ctrl #(.NUM_INPUTS(1), .NUM_OUTPUTS(1), .DIM(1), .DATA_SIZE(64)) dut_min (
    .clk(clk), .rst(rst), .start(m_start), .in_valid(m_in_valid), .in_data(m_in_data),
    .in_ready(m_in_ready), .weight_write(m_weight_write), .bias_write(m_bias_write),
    .index_in(m_index_in), .index_out(m_index_out), .index_k_y(m_index_k_y),
    .index_k_x(m_index_k_x), .out_data(m_out_data), .busy(m_busy), .done(m_done));

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0, exp_done = 0;
  int m_done_cnt = 0;
  wr_t exp_q[$];
  wr_t mexp_q[$];
  logic [63:0] mem_w [NI][NO][D][D];
  logic [63:0] mem_b [NO];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] wdata(input int k);
    return {16'hC0DE, 48'(k)};
  endfunction

  // Expected write for stream word k, straight from the index formulas.
  function automatic wr_t word_rec(input int k, input int ni, input int no, input int d);
    wr_t r;
    r.data = wdata(k);
    if (k < ni * no * d * d) begin
      r.is_bias = 1'b0;
      r.i  = 16'(k / (no * d * d));
      r.o  = 16'((k / (d * d)) % no);
      r.ky = 16'((k / d) % d);
      r.kx = 16'(k % d);
    end else begin
      r.is_bias = 1'b1;
      r.i = '0; r.o = '0; r.ky = '0;
      r.kx = 16'(k - ni * no * d * d);
    end
    return r;
  endfunction

  // Main monitor: compares every post-edge output set against the scoreboard.
  logic [15:0] p_in = '0, p_out = '0, p_ky = '0, p_kx = '0;
  logic [63:0] p_data = '0;
  always @(posedge clk) begin
    logic acc, r;
    wr_t e;
    acc = in_valid && in_ready && !rst;
    r   = rst;
    #1;
    check("strobe_exclusive", {63'd0, weight_write && bias_write}, 64'd0);
    if (r) begin
      check("rst_outputs", {60'd0, weight_write, bias_write, busy, done}, 64'd0);
      check("rst_index", {index_in, index_out, index_k_y, index_k_x}, 64'd0);
      check("rst_data", out_data, 64'd0);
    end else if (acc) begin
      check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_strobes", {62'd0, weight_write, bias_write}, {62'd0, !e.is_bias, e.is_bias});
        check("write_index", {index_in, index_out, index_k_y, index_k_x}, {e.i, e.o, e.ky, e.kx});
        check("write_data", out_data, e.data);
        if (weight_write) mem_w[index_in][index_out][index_k_y][index_k_x] = out_data;
        if (bias_write) mem_b[index_k_x] = out_data;
      end
    end else begin
      check("idle_strobes", {62'd0, weight_write, bias_write}, 64'd0);
      check("hold_index", {index_in, index_out, index_k_y, index_k_x}, {p_in, p_out, p_ky, p_kx});
      check("hold_data", out_data, p_data);
    end
    p_in = index_in; p_out = index_out; p_ky = index_k_y; p_kx = index_k_x; p_data = out_data;
    if (done) done_cnt++;
  end

  // Minimum-config monitor.
  always @(posedge clk) begin
    logic acc;
    wr_t e;
    acc = m_in_valid && m_in_ready && !rst;
    #1;
    if (acc) begin
      check("min_sb_nonempty", {63'd0, mexp_q.size() != 0}, 64'd1);
      if (mexp_q.size() != 0) begin
        e = mexp_q.pop_front();
        check("min_strobes", {62'd0, m_weight_write, m_bias_write}, {62'd0, !e.is_bias, e.is_bias});
        check("min_index", {m_index_in, m_index_out, m_index_k_y, m_index_k_x}, {e.i, e.o, e.ky, e.kx});
        check("min_data", m_out_data, e.data);
      end
    end else begin
      check("min_idle_strobes", {62'd0, m_weight_write, m_bias_write}, 64'd0);
    end
    if (m_done) m_done_cnt++;
  end

  task automatic clear_mem();
    for (int a = 0; a < NI; a++)
      for (int b = 0; b < NO; b++)
        for (int c = 0; c < D; c++)
          for (int d = 0; d < D; d++) mem_w[a][b][c][d] = 64'hDEAD_DEAD_DEAD_DEAD;
    for (int b = 0; b < NO; b++) mem_b[b] = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  task automatic verify_mem(input string tag);
    for (int k = 0; k < NT; k++) begin
      wr_t e = word_rec(k, NI, NO, D);
      if (!e.is_bias) check({tag, "_mem_w"}, mem_w[e.i][e.o][e.ky][e.kx], wdata(k));
      else check({tag, "_mem_b"}, mem_b[e.kx], wdata(k));
    end
  endtask

  // One load on the main instance, entered and left at a negedge.
  task automatic load(input int gap_every, input int start_at, input int rst_at, input int exp_cycles);
    int k = 0, slot = 0, guard = 0, cycles;
    bit gap;
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cycles = 1;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    while (k < NT && guard < 500) begin
      guard++;
      gap = (gap_every > 0) && ((slot % gap_every) == gap_every - 1);
      slot++;
      check("in_ready_loading", {63'd0, in_ready}, 64'd1);
      in_data = wdata(k);
      if (k == rst_at) begin
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("abort_ready", {63'd0, in_ready}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", {62'd0, done, busy}, 64'd0);
        end
        return;
      end
      in_valid = !gap;
      start = (k == start_at);
      if (!gap) exp_q.push_back(word_rec(k, NI, NO, D));
      @(negedge clk);
      cycles++;
      if (!gap) k++;
    end
    if (guard >= 500) check("load_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; start = 1'b0;
    check("flush_state", {60'd0, in_ready, busy, done, bias_write}, {60'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    cycles++;
    check("done_pulse", {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    check("load_cycles", 64'(cycles), 64'(exp_cycles));
    exp_done++;
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic min_load(input int base);
    m_in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("min_in_ready", {63'd0, m_in_ready}, 64'd1);
      m_in_data = wdata(base + k);
      mexp_q.push_back(word_rec(k, 1, 1, 1));
      mexp_q[$].data = wdata(base + k);
      @(negedge clk);
    end
    m_in_valid = 1'b0;
    check("min_flush", {61'd0, m_in_ready, m_busy, m_bias_write}, {61'd0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    check("min_done", {62'd0, m_done, m_busy}, {62'd0, 1'b1, 1'b0});
  endtask

  initial begin
    // Reset with start and in_valid held high.
    start = 1'b1; in_valid = 1'b1; m_start = 1'b1; m_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready_busy_done", {61'd0, in_ready, busy, done}, 64'd0);
      check("rst_min", {59'd0, m_in_ready, m_busy, m_done, m_weight_write, m_bias_write}, 64'd0);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; m_start = 1'b0; m_in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_not_ready", {62'd0, in_ready, busy}, 64'd0);
    end

    clear_mem(); load(0, -1, -1, NT + 2);  verify_mem("cont");
    clear_mem(); load(3, -1, -1, 42);      verify_mem("bp");
    clear_mem(); load(0, 5, -1, NT + 2);   verify_mem("start_ign");
    clear_mem(); load(0, -1, 10, 0);
    clear_mem(); load(0, -1, -1, NT + 2);  verify_mem("after_rst");
    check("done_count", 64'(done_cnt), 64'(exp_done));
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Minimum configuration, then a restart on the done cycle.
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    min_load(100);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    check("min_restart", {61'd0, m_busy, m_in_ready, m_done}, {61'd0, 1'b1, 1'b1, 1'b0});
    min_load(200);
    @(negedge clk);
    check("min_done_count", 64'(m_done_cnt), 64'd2);
    check("min_sb_drained", 64'(mexp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
